// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel timing, framebuffer read sequencing
// and registered sync/blank/colour outputs aligned to memory latency.
//
// Ports:
//   CLOCK_50    in   sole clock, rising edge
//   rst         in   asynchronous reset, active low
//   en          in   display enable request (taken at frame boundary)
//   fmt         in   pixel format, 0 = RGB565, 1 = 8-bit grey
//   q           in   framebuffer read data, RD_LATENCY clocks after rd_en
//   raddress    out  linear framebuffer address
//   rd_en       out  read strobe, one clock per visible pixel
//   vga_hs      out  horizontal sync (HS_POL when asserted)
//   vga_vs      out  vertical sync (VS_POL when asserted)
//   vga_blank_n out  high during visible pixels
//   red_o       out  red channel
//   green_o     out  green channel
//   blue_o      out  blue channel
//   frame_start out  one-clock pulse aligned with pixel (0,0)

module vga_scan_ctrl #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   CLK_DIV    = 2,
    parameter int   RD_LATENCY = 1,
    parameter int   ADDR_W     = 19,
    parameter int   COLOUR_W   = 6,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                en,
    input  logic                fmt,
    input  logic [15:0]         q,
    output logic [ADDR_W-1:0]   raddress,
    output logic                rd_en,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic [COLOUR_W-1:0] red_o,
    output logic [COLOUR_W-1:0] green_o,
    output logic [COLOUR_W-1:0] blue_o,
    output logic                frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int DCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    // Per-pixel attributes travelling down the read-latency delay line.
    typedef struct packed {
        logic first;
        logic hs;
        logic vs;
        logic act;
        logic vis;
        logic fs;
        logic fmt;
    } pix_t;

    function automatic logic in_range(
        input logic [31:0] x,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (x >= lo) && (x < hi);
    endfunction

    // Field f is MSB-aligned at bit 15 with fw meaningful bits.
    // Wider outputs: 6-bit channels repeat the field MSBs (565 -> 666),
    // other widths zero-pad; narrower outputs keep the top bits.
    function automatic logic [COLOUR_W-1:0] fit(
        input logic [15:0] f,
        input int          fw
    );
        logic [COLOUR_W-1:0] c;
        c = '0;
        for (int i = 0; i < COLOUR_W; i++) begin
            if (i < fw)
                c[COLOUR_W-1-i] = f[15-i];
            else if (COLOUR_W == 6)
                c[COLOUR_W-1-i] = f[15-(i-fw)];
        end
        return c;
    endfunction

    logic [DCW-1:0] div_cnt;
    logic           pix_ce;
    logic           pix_first;

    logic [HCW-1:0] h_cnt, h_nxt;
    logic [VCW-1:0] v_cnt, v_nxt;
    logic           h_last, v_last, wrap;
    logic           en_frame, en_nxt;
    logic           fmt_lat, fmt_nxt;
    logic           act_cur, act_nxt;

    pix_t           s0, tap;

    logic [COLOUR_W-1:0] r_c, g_c, b_c;

    // ---------------- pixel clock enable ----------------

    assign pix_ce = (div_cnt == DCW'(CLK_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DCW'(1);
        end
    end

    // High in the first clock of every pixel period. Reset value 1 so
    // pixel (0,0) right after release is issued like any other pixel.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            pix_first <= 1'b1;
        end else begin
            pix_first <= pix_ce;
        end
    end

    // ---------------- scan counters ----------------

    assign h_last = (h_cnt == HCW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VCW'(V_TOTAL - 1));
    assign wrap   = pix_ce & h_last & v_last;

    always_comb begin
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        en_nxt  = en_frame;
        fmt_nxt = fmt_lat;
        if (pix_ce) begin
            if (h_last) begin
                h_nxt = '0;
                if (v_last) begin
                    v_nxt   = '0;
                    en_nxt  = en;
                    fmt_nxt = fmt;
                end else begin
                    v_nxt = v_cnt + VCW'(1);
                end
            end else begin
                h_nxt = h_cnt + HCW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            en_frame <= 1'b0;
            fmt_lat  <= 1'b0;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            en_frame <= en_nxt;
            fmt_lat  <= fmt_nxt;
        end
    end

    assign act_cur = in_range(32'(h_cnt), 0, H_ACTIVE)
                   & in_range(32'(v_cnt), 0, V_ACTIVE);
    assign act_nxt = in_range(32'(h_nxt), 0, H_ACTIVE)
                   & in_range(32'(v_nxt), 0, V_ACTIVE);

    // ---------------- read sequencing ----------------

    // The read is issued in the same edge that moves the counters onto
    // the pixel, so data returns RD_LATENCY clocks later and the output
    // register captures it one clock after that.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            rd_en <= 1'b0;
        end else begin
            rd_en <= pix_ce & act_nxt & en_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            raddress <= '0;
        end else if (wrap) begin
            raddress <= '0;
        end else if (rd_en) begin
            raddress <= raddress + ADDR_W'(1);
        end
    end

    // ---------------- timing delay line ----------------

    always_comb begin
        s0       = '0;
        s0.first = pix_first;
        s0.hs    = in_range(32'(h_cnt), HS_LO, HS_HI);
        s0.vs    = in_range(32'(v_cnt), VS_LO, VS_HI);
        s0.act   = act_cur;
        s0.vis   = act_cur & en_frame;
        s0.fs    = (h_cnt == '0) && (v_cnt == '0);
        s0.fmt   = fmt_lat;
    end

    generate
        if (RD_LATENCY == 0) begin : g_nodly
            assign tap = s0;
        end else begin : g_dly
            pix_t sr [RD_LATENCY];

            always_ff @(posedge CLOCK_50 or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < RD_LATENCY; i++)
                        sr[i] <= '0;
                end else begin
                    sr[0] <= s0;
                    for (int i = 1; i < RD_LATENCY; i++)
                        sr[i] <= sr[i-1];
                end
            end

            assign tap = sr[RD_LATENCY-1];
        end
    endgenerate

    // ---------------- colour decode ----------------

    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        if (tap.fmt) begin
            r_c = fit({q[7:0], 8'h00}, 8);
            g_c = r_c;
            b_c = r_c;
        end else begin
            r_c = fit({q[15:11], 11'h000}, 5);
            g_c = fit({q[10:5], 10'h000}, 6);
            b_c = fit({q[4:0], 11'h000}, 5);
        end
    end

    // ---------------- output register ----------------

    // Loaded once per pixel so every output holds for the full period.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_blank_n <= 1'b0;
            red_o       <= '0;
            green_o     <= '0;
            blue_o      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tap.first & tap.fs;
            if (tap.first) begin
                vga_hs      <= tap.hs ? HS_POL : ~HS_POL;
                vga_vs      <= tap.vs ? VS_POL : ~VS_POL;
                vga_blank_n <= tap.act;
                if (tap.vis) begin
                    red_o   <= r_c;
                    green_o <= g_c;
                    blue_o  <= b_c;
                end else begin
                    red_o   <= '0;
                    green_o <= '0;
                    blue_o  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a reduced 8x6 raster,
// CLK_DIV=2, RD_LATENCY=1 (96 clocks per frame).

module tb_vga_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fmt;
    logic [15:0] q;
    logic [18:0] raddress;
    logic        rd_en;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [5:0]  red_o;
    logic [5:0]  green_o;
    logic [5:0]  blue_o;
    logic        frame_start;

    vga_scan_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .RD_LATENCY(1), .ADDR_W(19), .COLOUR_W(6),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .CLOCK_50(clk),
        .rst(rst),
        .en(en),
        .fmt(fmt),
        .q(q),
        .raddress(raddress),
        .rd_en(rd_en),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .red_o(red_o),
        .green_o(green_o),
        .blue_o(blue_o),
        .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int badcol = 0;

    int hs_lo[4];
    int vs_lo[4];
    int blk[4];
    int fs_n[4];
    int fs_pos[4];
    int colnz[4];
    int rd_n[4];
    int exp_a[4];
    int addr_bad[4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            hs_lo[i] = 0; vs_lo[i] = 0; blk[i] = 0; fs_n[i] = 0;
            fs_pos[i] = 0; colnz[i] = 0; rd_n[i] = 0;
            exp_a[i] = 0; addr_bad[i] = 0;
        end
    endtask

    // One clock; outputs of frame f fall in cycles [96f+2, 96f+97],
    // reads of frame f in cycles [96f, 96f+95].
    task automatic step();
        int fo;
        int fr;
        @(posedge clk);
        #1;
        cyc++;
        if (!vga_blank_n && (|{red_o, green_o, blue_o}))
            badcol++;
        if (cyc >= 2) begin
            fo = (cyc - 2) / 96;
            if (fo < 4) begin
                if (!vga_hs) hs_lo[fo]++;
                if (!vga_vs) vs_lo[fo]++;
                if (vga_blank_n) blk[fo]++;
                if (|{red_o, green_o, blue_o}) colnz[fo]++;
                if (frame_start) begin
                    fs_n[fo]++;
                    fs_pos[fo] = cyc;
                end
            end
        end
        fr = cyc / 96;
        if (fr < 4 && rd_en) begin
            rd_n[fr]++;
            if (raddress !== 19'(exp_a[fr])) addr_bad[fr]++;
            exp_a[fr]++;
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        fmt = 1'b0;
        q   = 16'h0000;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_raddr", raddress, 0);
        chk("rst_blank", vga_blank_n, 0);
        chk("rst_red", red_o, 0);
        chk("rst_green", green_o, 0);
        chk("rst_blue", blue_o, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);

        en  = 1'b1;
        q   = 16'hF800;
        rst = 1'b1;
        cyc = 0;

        while (cyc < 96) step();
        chk("f1_first_rd", rd_en, 1);
        chk("f1_first_addr", raddress, 0);
        step();
        chk("pre_blank", vga_blank_n, 0);
        chk("pre_red", red_o, 0);
        step();
        chk("rgb_blank", vga_blank_n, 1);
        chk("rgb_red", red_o, 6'h3F);
        chk("rgb_green0", green_o, 0);
        chk("rgb_blue0", blue_o, 0);
        chk("f1_fs", frame_start, 1);
        step();
        chk("fs_one_clk", frame_start, 0);
        chk("red_hold", red_o, 6'h3F);
        step();
        q = 16'h07E0;
        step();
        chk("red_hold2", red_o, 6'h3F);
        step();
        chk("g_green", green_o, 6'h3F);
        chk("g_red0", red_o, 0);
        chk("g_blue0", blue_o, 0);
        while (cyc < 120) step();
        fmt = 1'b1;
        while (cyc < 131) step();
        chk("fmt_midframe", green_o, 6'h3F);
        while (cyc < 140) step();
        q = 16'h00A4;
        while (cyc < 192) step();
        chk("wrap_rd", rd_en, 1);
        chk("wrap_addr", raddress, 0);
        while (cyc < 194) step();
        chk("grey_r", red_o, 6'h29);
        chk("grey_g", green_o, 6'h29);
        chk("grey_b", blue_o, 6'h29);
        chk("f2_fs", frame_start, 1);
        while (cyc < 200) step();
        en = 1'b0;
        while (cyc < 202) step();
        chk("porch_blank", vga_blank_n, 0);
        chk("porch_red", red_o, 0);
        chk("porch_green", green_o, 0);
        while (cyc < 300) step();
        en = 1'b1;
        while (cyc < 385) step();

        chk("f0_rd", rd_n[0], 0);
        chk("f0_col", colnz[0], 0);
        chk("f0_blk", blk[0], 24);
        chk("f0_hs", hs_lo[0], 24);
        chk("f0_vs", vs_lo[0], 16);
        chk("f0_fsn", fs_n[0], 1);
        chk("f0_fspos", fs_pos[0], 2);
        chk("f1_rd", rd_n[1], 12);
        chk("f1_addr", addr_bad[1], 0);
        chk("f1_col", colnz[1], 24);
        chk("f1_fspos", fs_pos[1], 98);
        chk("f1_hs", hs_lo[1], 24);
        chk("f1_vs", vs_lo[1], 16);
        chk("f2_rd", rd_n[2], 12);
        chk("f2_addr", addr_bad[2], 0);
        chk("f2_col", colnz[2], 24);
        chk("f2_fspos", fs_pos[2], 194);
        chk("f3_rd", rd_n[3], 0);
        chk("f3_col", colnz[3], 0);
        chk("f3_fsn", fs_n[3], 1);
        chk("f3_hs", hs_lo[3], 24);
        chk("f3_vs", vs_lo[3], 16);
        chk("f3_blk", blk[3], 24);

        while (cyc < 388) step();
        chk("f4_grey", red_o, 6'h29);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_blank", vga_blank_n, 0);
        chk("mid_rst_red", red_o, 0);
        chk("mid_rst_green", green_o, 0);
        chk("mid_rst_addr", raddress, 0);
        chk("mid_rst_rd", rd_en, 0);
        chk("mid_rst_hs", vga_hs, 1);
        chk("mid_rst_fs", frame_start, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        clr();
        while (cyc < 193) step();
        chk("r0_fspos", fs_pos[0], 2);
        chk("r0_rd", rd_n[0], 0);
        chk("r0_col", colnz[0], 0);
        chk("r0_blk", blk[0], 24);
        chk("r0_hs", hs_lo[0], 24);
        chk("r0_vs", vs_lo[0], 16);
        chk("r1_rd", rd_n[1], 12);
        chk("r1_addr", addr_bad[1], 0);
        chk("r1_col", colnz[1], 24);
        chk("r1_fspos", fs_pos[1], 98);
        chk("blank_col", badcol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
